// File: rtl/ustc_pkg.sv
// Shared line-layout definitions for the fan adders and fan collector.
// A line is packed LSB-first as ctrl, then row id, then data words.
package ustc_pkg;

  localparam int CTRL_LSB     = 0;
  localparam int CTRL_SEG_END = 0;

  function automatic int row_lsb(input int dw_ctrl);
    return CTRL_LSB + dw_ctrl;
  endfunction

  function automatic int data_lsb(input int dw_ctrl, input int dw_row);
    return CTRL_LSB + dw_ctrl + dw_row;
  endfunction

  function automatic int lane_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ustc_prio_enc.sv
// Lowest-set-bit select: one-hot of the lowest request, its index, and any-set.
module ustc_prio_enc
  import ustc_pkg::*;
#(
  parameter  int N     = 32,
  localparam int IDX_W = lane_w(N)
) (
  input  logic [N-1:0]     req,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  assign onehot = req & (~req + N'(1));
  assign any    = |req;

  // Scanning downward so the last hit wins leaves the lowest set index.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/ustc_fan_collect.sv
// Holds one reduced vector and drains its segment-end lines one per cycle,
// lowest line index first.
module ustc_fan_collect
  import ustc_pkg::*;
#(
  parameter  int NUM_IN  = 32,
  parameter  int N_STACK = 4,
  parameter  int DW_DATA = 32,
  parameter  int DW_ROW  = 4,
  parameter  int DW_CTRL = 4,
  localparam int DW_LINE = N_STACK * DW_DATA + DW_ROW + DW_CTRL,
  localparam int LANE_W  = lane_w(NUM_IN)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_IN*DW_LINE-1:0] in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_STACK*DW_DATA-1:0] out_data,
  output logic [DW_ROW-1:0]         out_row,
  output logic [DW_CTRL-1:0]        out_ctrl,
  output logic [LANE_W-1:0]         out_lane,
  output logic                      out_last,
  output logic [15:0]               vec_cnt
);

  localparam int ROW_LSB  = row_lsb(DW_CTRL);
  localparam int DATA_LSB = data_lsb(DW_CTRL, DW_ROW);

  logic [NUM_IN*DW_LINE-1:0] hold_q, hold_d;
  logic [NUM_IN-1:0]         pend_q, pend_d;
  logic [15:0]               vec_cnt_q, vec_cnt_d;
  logic [NUM_IN-1:0]         seg_mask;
  logic [NUM_IN-1:0]         sel_onehot;
  logic [LANE_W-1:0]         sel_idx;
  logic                      sel_any;
  logic [DW_LINE-1:0]        sel_line;
  logic                      accept;
  logic                      consume;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    seg_mask = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      seg_mask[k] = in[k*DW_LINE + CTRL_LSB + CTRL_SEG_END];
    end
  end

  ustc_prio_enc #(.N(NUM_IN)) u_prio_enc (
    .req    (pend_q),
    .onehot (sel_onehot),
    .idx    (sel_idx),
    .any    (sel_any)
  );

  assign sel_line  = hold_q[int'(sel_idx)*DW_LINE +: DW_LINE];
  assign out_valid = sel_any;
  assign out_last  = sel_any && ((pend_q & (pend_q - NUM_IN'(1))) == '0);
  assign in_ready  = !sel_any || (out_last && out_ready);
  assign out_data  = sel_any ? sel_line[DATA_LSB +: N_STACK*DW_DATA] : '0;
  assign out_row   = sel_any ? sel_line[ROW_LSB +: DW_ROW] : '0;
  assign out_ctrl  = sel_any ? sel_line[CTRL_LSB +: DW_CTRL] : '0;
  assign out_lane  = sel_any ? sel_idx : '0;
  assign vec_cnt   = vec_cnt_q;

  assign accept  = in_valid && in_ready;
  assign consume = out_valid && out_ready;

  // A new vector overrides the drain update: accepting while pending is
  // non-empty only happens as the last result leaves.
  always_comb begin
    hold_d    = hold_q;
    pend_d    = pend_q;
    vec_cnt_d = vec_cnt_q;
    if (consume) pend_d = pend_q & ~sel_onehot;
    if (accept) begin
      hold_d    = in;
      pend_d    = seg_mask;
      vec_cnt_d = vec_cnt_q + 16'd1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples its _d value from the same pre-edge snapshot.
  // NOTE: the wide holding register is reset too, so the discarded vector
  // can never reappear on the outputs after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q    <= '0;
      pend_q    <= '0;
      vec_cnt_q <= '0;
    end else begin
      hold_q    <= hold_d;
      pend_q    <= pend_d;
      vec_cnt_q <= vec_cnt_d;
    end
  end

endmodule

// File: tb/tb_ustc_fan_collect.sv
// Directed bench for ustc_fan_collect: drain order, stalls, back-to-back
// vectors, empty vectors, reset mid-drain and vec_cnt wrap.
module tb_ustc_fan_collect;

  localparam int NUM_IN  = 32;
  localparam int N_STACK = 4;
  localparam int DW_DATA = 32;
  localparam int DW_ROW  = 4;
  localparam int DW_CTRL = 4;
  localparam int DW_LINE = N_STACK * DW_DATA + DW_ROW + DW_CTRL;
  localparam int IN_W    = NUM_IN * DW_LINE;
  localparam int DATA_W  = N_STACK * DW_DATA;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_bus;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [DW_ROW-1:0] out_row;
  logic [DW_CTRL-1:0] out_ctrl;
  logic [4:0]        out_lane;
  logic              out_last;
  logic [15:0]       vec_cnt;

  int n_pass;
  int n_total;

  ustc_fan_collect #(
    .NUM_IN (NUM_IN), .N_STACK(N_STACK), .DW_DATA(DW_DATA),
    .DW_ROW (DW_ROW), .DW_CTRL(DW_CTRL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in       (in_bus),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_row  (out_row),
    .out_ctrl (out_ctrl),
    .out_lane (out_lane),
    .out_last (out_last),
    .vec_cnt  (vec_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data word j of line k is 0xD000_kk0j; row = k[3:0]; ctrl = {k[2:0], seg}.
  function automatic logic [DATA_W-1:0] exp_data(input int lane);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int j = 0; j < N_STACK; j++) d[j*DW_DATA +: DW_DATA] = 32'hD000_0000 | 32'(lane << 8) | 32'(j);
    return d;
  endfunction

  function automatic logic [IN_W-1:0] make_vec(input logic [31:0] mask);
    logic [IN_W-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      v[k*DW_LINE + 8 +: DATA_W] = exp_data(k);
      v[k*DW_LINE + 4 +: 4]      = 4'(k);
      v[k*DW_LINE +: 4]          = {3'(k), mask[k]};
    end
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_bus = '0;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++;
    if ({out_valid, out_last, in_ready, vec_cnt, out_lane, out_data, out_row, out_ctrl} !==
        {1'b0, 1'b0, 1'b1, 16'h0, 5'd0, {DATA_W{1'b0}}, 4'h0, 4'h0})
      $display("FAIL reset_state: got v=%b l=%b r=%b cnt=%h lane=%0d", out_valid, out_last, in_ready, vec_cnt, out_lane);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic apply_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_three_results();
    int lanes[3] = '{3, 8, 31};
    out_ready = 1'b1;
    in_bus    = make_vec(32'h8000_0108);
    in_valid  = 1'b1;
    @(negedge clk);
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL three_accept: in_ready=%b expected 1", in_ready);
    else n_pass++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++;
      if ({out_valid, out_lane, out_last, in_ready} !== {1'b1, 5'(lanes[i]), 1'(i == 2), 1'(i == 2)})
        $display("FAIL three_lane%0d: v=%b lane=%0d last=%b rdy=%b expected lane=%0d", i, out_valid, out_lane, out_last, in_ready, lanes[i]);
      else n_pass++;
      n_total++;
      if ({out_data, out_row, out_ctrl} !== {exp_data(lanes[i]), 4'(lanes[i]), {3'(lanes[i]), 1'b1}})
        $display("FAIL three_payload%0d: row=%h ctrl=%h data=%h expected row=%h", i, out_row, out_ctrl, out_data, 4'(lanes[i]));
      else n_pass++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_total++;
    if ({out_valid, out_lane, out_data, vec_cnt} !== {1'b0, 5'd0, {DATA_W{1'b0}}, 16'd1})
      $display("FAIL three_idle: v=%b lane=%0d cnt=%0d expected v=0 lane=0 cnt=1", out_valid, out_lane, vec_cnt);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_empty_vectors();
    apply_reset();
    in_bus   = make_vec(32'h0);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++;
      if ({in_ready, out_valid} !== 2'b10)
        $display("FAIL empty_cycle%0d: in_ready=%b out_valid=%b expected 1 0", i, in_ready, out_valid);
      else n_pass++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_total++;
    if ({out_valid, vec_cnt} !== {1'b0, 16'd3})
      $display("FAIL empty_count: out_valid=%b vec_cnt=%0d expected 0 3", out_valid, vec_cnt);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    in_bus    = make_vec(32'h0000_0003);
    in_valid  = 1'b1;
    @(posedge clk); #1;
    // Offered while not ready: must be ignored.
    in_bus = make_vec(32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_total++;
      if ({out_valid, out_lane, out_last, in_ready, out_data} !== {1'b1, 5'd0, 1'b0, 1'b0, exp_data(0)})
        $display("FAIL stall_cycle%0d: v=%b lane=%0d last=%b rdy=%b expected lane 0 held", i, out_valid, out_lane, out_last, in_ready);
      else n_pass++;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++;
    if ({out_valid, out_lane, out_last, in_ready, out_data, out_ctrl} !== {1'b1, 5'd1, 1'b1, 1'b1, exp_data(1), 4'b0011})
      $display("FAIL stall_second: v=%b lane=%0d last=%b rdy=%b ctrl=%h expected lane 1 last", out_valid, out_lane, out_last, in_ready, out_ctrl);
    else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++;
    if ({out_valid, vec_cnt} !== {1'b0, 16'd4})
      $display("FAIL stall_done: out_valid=%b vec_cnt=%0d expected 0 4", out_valid, vec_cnt);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_bus    = make_vec(32'h0000_0100);
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_bus = make_vec(32'h0000_0004);
    @(negedge clk);
    n_total++;
    if ({out_valid, out_lane, out_last, in_ready} !== {1'b1, 5'd8, 1'b1, 1'b1})
      $display("FAIL b2b_first: v=%b lane=%0d last=%b rdy=%b expected lane 8 last ready", out_valid, out_lane, out_last, in_ready);
    else n_pass++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_total++;
    if ({out_valid, out_lane, out_last, out_data} !== {1'b1, 5'd2, 1'b1, exp_data(2)})
      $display("FAIL b2b_second: v=%b lane=%0d last=%b expected lane 2 with no bubble", out_valid, out_lane, out_last);
    else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++;
    if ({out_valid, vec_cnt} !== {1'b0, 16'd6})
      $display("FAIL b2b_done: out_valid=%b vec_cnt=%0d expected 0 6", out_valid, vec_cnt);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_drain();
    out_ready = 1'b1;
    in_bus    = make_vec(32'h0010_0220);
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_total++;
    if ({out_valid, out_lane} !== {1'b1, 5'd5})
      $display("FAIL middrain_first: v=%b lane=%0d expected lane 5", out_valid, out_lane);
    else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_total++;
    if ({out_valid, out_last, in_ready, vec_cnt, out_lane, out_data, out_row, out_ctrl} !==
        {1'b0, 1'b0, 1'b1, 16'h0, 5'd0, {DATA_W{1'b0}}, 4'h0, 4'h0})
      $display("FAIL middrain_reset: v=%b last=%b rdy=%b cnt=%0d lane=%0d expected cleared", out_valid, out_last, in_ready, vec_cnt, out_lane);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++;
      if ({out_valid, vec_cnt} !== {1'b0, 16'd0})
        $display("FAIL middrain_stale%0d: out_valid=%b vec_cnt=%0d expected 0 0", i, out_valid, vec_cnt);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    out_ready = 1'b1;
    in_bus    = make_vec(32'h0);
    in_valid  = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    n_total++;
    if (vec_cnt !== 16'hFFFF) $display("FAIL wrap_max: vec_cnt=%h expected ffff", vec_cnt);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (vec_cnt !== 16'h0000) $display("FAIL wrap_zero: vec_cnt=%h expected 0000", vec_cnt);
    else n_pass++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_total++;
    if ({vec_cnt, out_valid} !== {16'h0001, 1'b0})
      $display("FAIL wrap_one: vec_cnt=%h out_valid=%b expected 0001 0", vec_cnt, out_valid);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_three_results();
    test_empty_vectors();
    test_stall();
    test_back_to_back();
    test_reset_mid_drain();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ustc_fan_collect.md
USTC_FAN_COLLECT -- requirements
Module: ustc_fan_collect

Interface
REQ-001 SHALL have parameter NUM_IN, default 32: lines per reduction-network output vector.
REQ-002 SHALL have parameter N_STACK, default 4: data words per line.
REQ-003 SHALL have parameter DW_DATA, default 32: bits per data word.
REQ-004 SHALL have parameter DW_ROW, default 4: row-id bits per line.
REQ-005 SHALL have parameter DW_CTRL, default 4: control bits per line.
REQ-006 SHALL have derived parameter DW_LINE = N_STACK*DW_DATA + DW_ROW + DW_CTRL; line layout from LSB is ctrl, then row, then data.
REQ-007 SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-008 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port in_valid, input, 1 bit: a reduced vector is offered.
REQ-010 SHALL have port in_ready, output, 1 bit: the vector is accepted this cycle.
REQ-011 SHALL have port in, input, NUM_IN*DW_LINE bits: line k occupies [k*DW_LINE +: DW_LINE].
REQ-012 SHALL have port out_valid, output, 1 bit: one reduced result is offered.
REQ-013 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-014 SHALL have port out_data, output, N_STACK*DW_DATA bits: result data.
REQ-015 SHALL have port out_row, output, DW_ROW bits: result row id.
REQ-016 SHALL have port out_ctrl, output, DW_CTRL bits: result ctrl, passed through unchanged.
REQ-017 SHALL have port out_lane, output, clog2(NUM_IN) bits: source line index.
REQ-018 SHALL have port out_last, output, 1 bit: this is the final result of the current vector.
REQ-019 SHALL have port vec_cnt, output, 16 bits: count of accepted vectors.

Function
REQ-020 SHALL treat line k as a result iff ctrl bit 0 of line k is 1 (segment end).
REQ-021 SHALL capture `in` into a holding register and form an NUM_IN-bit pending mask from the ctrl bit 0 values when in_valid and in_ready are both 1.
REQ-022 SHALL drive out_valid = OR of the pending mask.
- out_data, out_row, out_ctrl and out_lane come from the lowest-index pending line.
REQ-023 SHALL assert out_last when exactly one pending bit remains.
REQ-024 SHALL clear the lowest pending bit on each out_valid and out_ready handshake.
- Throughput: one result per cycle.
REQ-025 SHALL hold all out_* stable while out_valid=1 and out_ready=0.
REQ-026 SHALL drive in_ready = (pending == 0) OR (out_last AND out_ready); this is the only combinational in-to-out path.
REQ-027 SHALL present the first result of a vector accepted in cycle t with out_valid=1 in cycle t+1.
- When the last result is consumed and a new vector is accepted in the same cycle, there is no bubble.
REQ-028 SHALL consume a vector with no ctrl bit 0 set in one cycle and emit no output.
- in_ready stays 1 for the following vectors.
REQ-029 SHALL ignore `in` while in_ready=0; the holding register is not disturbed.
REQ-030 SHALL increment vec_cnt by 1 per accepted vector, wrapping from 0xFFFF to 0x0000.
REQ-031 SHALL hold out_data/out_row/out_ctrl/out_lane at 0 whenever out_valid=0.

Reset
REQ-032 SHALL, on rst=0 at any time including mid-drain, immediately clear the pending mask, the holding register and vec_cnt.
- Outputs are then out_valid=0, out_last=0, all out_* 0 and in_ready=1.
- Undelivered results are discarded.
REQ-033 SHALL resume normal operation on the first rising clk edge after rst returns to 1.

Structure
REQ-034 SHALL take DW_LINE field offsets and the ctrl bit 0 position (CTRL_SEG_END) from the shared ustc package also used by the fan adders.
REQ-035 SHALL implement the lowest-set-bit select in one sub-module, ustc_prio_enc (NUM_IN in; one-hot, index and any-set out).

Verification
REQ-036 SHALL verify: vector with results on lines 3, 8 and 31, out_ready=1 -> out_lane 3, 8, 31 in cycles t+1..t+3; out_last only at 31; in_ready=1 in t+3.
REQ-037 SHALL verify: no result lines, in_valid held for 3 cycles -> 3 accepts, no out_valid, vec_cnt=3.
REQ-038 SHALL verify: results on lines 0 and 1, out_ready low for 5 cycles -> lane 0 outputs stable for 5 cycles, in_ready=0 throughout.
REQ-039 SHALL verify: back-to-back vectors with single results on line 8 and then line 2 -> lanes 8 and 2 on consecutive cycles, no bubble.
REQ-040 SHALL verify: rst=0 asserted mid-drain with 2 results pending -> out_valid=0 and vec_cnt=0 immediately; no stale result after release.
REQ-041 SHALL verify: 65537 accepted vectors -> vec_cnt=1.
